pix_cmp_acc: RTL and testbench
==============================

Name: pix_cmp_acc

Overview:
- Streaming hardware successor to the software image-comparison function.
- Accepts pixel pairs from two images of WIDTH x HEIGHT pixels, each with CH_NUM channels.
- Accumulates the per-channel sum of squared differences in a 3-stage pipeline.
- At end of frame, reports per-channel losses, the total loss, and a match flag against a programmable threshold. Sits between the frame readers and the verification scoreboard.

Parameters:
- CH_NUM, 3, number of colour channels per pixel.
- PIX_W, 8, bits per channel sample (unsigned).
- WIDTH, 640, pixels per line.
- HEIGHT, 480, lines per frame.
- ACC_W, 2*PIX_W+$clog2(WIDTH*HEIGHT)+1, per-channel accumulator width (derived; not to be overridden smaller).
- TOT_W, ACC_W+$clog2(CH_NUM)+1, total-loss width (derived).

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset.
- start, in, 1, pulse: begin new frame comparison.
- pix_valid, in, 1, a_pix/b_pix hold a valid pixel pair.
- pix_ready, out, 1, block accepts a pixel pair this cycle.
- a_pix, in, CH_NUM*PIX_W, image A pixel; channel k at bits [k*PIX_W +: PIX_W].
- b_pix, in, CH_NUM*PIX_W, image B pixel; same packing as a_pix.
- threshold, in, TOT_W, maximum total loss still counted as a match; sampled on start.
- busy, out, 1, comparison in progress.
- done, out, 1, one-cycle pulse: results valid.
- ch_loss, out, CH_NUM*ACC_W, per-channel sum of squared differences.
- total_loss, out, TOT_W, sum of all ch_loss fields.
- match, out, 1, total_loss <= latched threshold.

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset values: all outputs 0; FSM in IDLE; accumulators, counters and pipeline valid bits cleared.
- A pixel pair transfers on a cycle where pix_valid && pix_ready.
- FSM states and transitions:
  - IDLE: pix_ready=0, busy=0. On start: clear accumulators and pixel counter, latch threshold, go to RUN.
  - RUN: pix_ready=1, busy=1. Each transfer increments pix_cnt (0 .. WIDTH*HEIGHT-1). A transfer at pix_cnt==WIDTH*HEIGHT-1 goes to DRAIN; pix_cnt wraps to 0.
  - DRAIN: pix_ready=0, busy=1. Waits until the pipeline is empty (all stage valids 0), then goes to DONE.
  - DONE: single cycle. Computes total_loss and match, asserts done for exactly 1 cycle, returns to IDLE. ch_loss, total_loss and match hold until the next start.
- Pipeline, per channel:
  - S1: d = a - b as signed PIX_W+1 bits.
  - S2: sq = d*d as unsigned 2*PIX_W bits.
  - S3: acc += sq.
  - Each stage carries a valid bit. Latency from last transfer to done = 4 cycles.
- Arithmetic: accumulators are sized so overflow is impossible for a full frame; no saturation logic.
- Simultaneous events:
  - start outside IDLE is ignored.
  - pix_valid outside RUN is ignored (pix_ready=0).
  - start and rst in the same cycle: reset wins.
  - rst mid-frame: aborts immediately, no done pulse, outputs return to 0.
- Gaps in pix_valid during RUN are allowed; the pipeline advances with bubbles.

Optional Feature:
- Macro: PIX_CMP_MAX_EN.
- When defined:
  - Adds output max_diff, CH_NUM*PIX_W bits: per-channel maximum |a-b| over the frame.
  - Updated at S2 from |d|; cleared on start; held with the other results.
- When undefined: port and logic absent; all other behaviour identical.

Test Plan:
- WIDTH=4, HEIGHT=2, CH_NUM=3: 8 pairs with a==b, threshold=0 -> done 4 cycles after last transfer; ch_loss all 0, total_loss=0, match=1.
- Same size: every pair a={10,20,30}, b={13,16,30} -> ch_loss={72,128,0}, total_loss=200; threshold=199 -> match=0; threshold=200 -> match=1.
- Extreme values: a=255, b=0 on all channels for 8 pixels -> each ch_loss=520200, total_loss=1560600; no overflow.
- Random pix_valid gaps (~50% duty) with same data as the second case -> identical results; pix_ready=0 in DRAIN; exactly 8 transfers accepted.
- rst asserted after 5 transfers -> no done; outputs 0. A new start then a full frame -> correct results. A start pulse during RUN -> ignored, count unaffected.
- With PIX_CMP_MAX_EN: one pixel a=100, b=40 on channel 1, all others equal -> max_diff channel 1 = 60, other channels 0.

Source files
------------

// File: rtl/pix_cmp_acc_if.sv
// +--------------------------------------------------------------------------+
// | pix_cmp_acc_if : pixel-pair stream, control and result bundle            |
// | PIX_CMP_MAX_EN adds the per-channel max_diff result.  Rev 1.0            |
// +--------------------------------------------------------------------------+
`default_nettype none

interface pix_cmp_acc_if #(
    parameter int CH_NUM = 3,
    parameter int PIX_W  = 8,
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int ACC_W  = 2*PIX_W + $clog2(WIDTH*HEIGHT) + 1,
    parameter int TOT_W  = ACC_W + $clog2(CH_NUM) + 1
);
    logic                      start;
    logic [TOT_W-1:0]          threshold;
    logic                      pix_valid;
    logic                      pix_ready;
    logic [CH_NUM*PIX_W-1:0]   a_pix;
    logic [CH_NUM*PIX_W-1:0]   b_pix;
    logic                      busy;
    logic                      done;
    logic [CH_NUM*ACC_W-1:0]   ch_loss;
    logic [TOT_W-1:0]          total_loss;
    logic                      match;
`ifdef PIX_CMP_MAX_EN
    logic [CH_NUM*PIX_W-1:0]   max_diff;

    modport master (
        output start, threshold, pix_valid, a_pix, b_pix,
        input  pix_ready, busy, done, ch_loss, total_loss, match, max_diff
    );
    modport slave (
        input  start, threshold, pix_valid, a_pix, b_pix,
        output pix_ready, busy, done, ch_loss, total_loss, match, max_diff
    );
`else
    modport master (
        output start, threshold, pix_valid, a_pix, b_pix,
        input  pix_ready, busy, done, ch_loss, total_loss, match
    );
    modport slave (
        input  start, threshold, pix_valid, a_pix, b_pix,
        output pix_ready, busy, done, ch_loss, total_loss, match
    );
`endif
endinterface

`default_nettype wire

// File: rtl/pix_cmp_acc.sv
// +--------------------------------------------------------------------------+
// | pix_cmp_acc : streaming per-channel sum-of-squared-differences comparator|
// | Optional macro PIX_CMP_MAX_EN adds max |a-b| per channel.  Rev 1.0       |
// +--------------------------------------------------------------------------+
`default_nettype none

module pix_cmp_acc #(
    parameter int CH_NUM = 3,
    parameter int PIX_W  = 8,
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int ACC_W  = 2*PIX_W + $clog2(WIDTH*HEIGHT) + 1,
    parameter int TOT_W  = ACC_W + $clog2(CH_NUM) + 1
) (
    input  logic              clk,
    input  logic              rst,
    pix_cmp_acc_if.slave      bus
);
    localparam int NPIX  = WIDTH * HEIGHT;
    localparam int CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NPIX - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]             r_state;
    logic [1:0]             w_next;
    logic                   w_ready;
    logic                   w_busy;
    logic                   w_done;
    logic                   w_start;
    logic                   w_xfer;
    logic                   w_empty;
    logic                   w_finish;

    logic [CNT_W-1:0]       r_pix_cnt;
    logic                   r_s1_v;
    logic                   r_s2_v;
    logic                   r_s3_v;
    logic signed [PIX_W:0]  r_d   [CH_NUM];
    logic [PIX_W-1:0]       w_abs [CH_NUM];
    logic [2*PIX_W-1:0]     r_sq  [CH_NUM];
    logic [ACC_W-1:0]       r_acc [CH_NUM];
    logic [TOT_W-1:0]       r_thresh;
    logic [TOT_W-1:0]       r_total;
    logic [TOT_W-1:0]       w_total;
    logic                   r_match;
`ifdef PIX_CMP_MAX_EN
    logic [PIX_W-1:0]       r_max [CH_NUM];
`endif

    assign w_start  = bus.start && (r_state == S_IDLE);
    assign w_xfer   = bus.pix_valid && w_ready;
    assign w_empty  = !(r_s1_v || r_s2_v || r_s3_v);
    assign w_finish = (r_state == S_DRAIN) && w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_RUN;
            S_RUN:   if (w_xfer && (r_pix_cnt == LAST_PIX)) w_next = S_DRAIN;
            S_DRAIN: if (w_empty) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ready = 1'b0;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            S_RUN:   begin w_ready = 1'b1; w_busy = 1'b1; end
            S_DRAIN: w_busy = 1'b1;
            S_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    // Magnitude of the stage-1 difference; feeds both the squarer and max tracking.
    always_comb begin
        for (int k = 0; k < CH_NUM; k++) begin
            w_abs[k] = r_d[k][PIX_W] ? PIX_W'(-r_d[k]) : PIX_W'(r_d[k]);
        end
    end

    always_comb begin
        w_total = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            w_total = w_total + TOT_W'(r_acc[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix_cnt <= '0;
            r_s1_v    <= 1'b0;
            r_s2_v    <= 1'b0;
            r_s3_v    <= 1'b0;
            r_thresh  <= '0;
            r_total   <= '0;
            r_match   <= 1'b0;
            for (int k = 0; k < CH_NUM; k++) begin
                r_d[k]   <= '0;
                r_sq[k]  <= '0;
                r_acc[k] <= '0;
`ifdef PIX_CMP_MAX_EN
                r_max[k] <= '0;
`endif
            end
        end else begin
            r_s1_v <= w_xfer;
            r_s2_v <= r_s1_v;
            r_s3_v <= r_s2_v;
            if (w_start) begin
                r_pix_cnt <= '0;
                r_thresh  <= bus.threshold;
                r_total   <= '0;
                r_match   <= 1'b0;
            end else if (w_xfer) begin
                r_pix_cnt <= (r_pix_cnt == LAST_PIX) ? '0 : r_pix_cnt + 1'b1;
            end
            if (w_finish) begin
                r_total <= w_total;
                r_match <= (w_total <= r_thresh);
            end
            for (int k = 0; k < CH_NUM; k++) begin
                if (w_xfer) begin
                    r_d[k] <= $signed({1'b0, bus.a_pix[k*PIX_W +: PIX_W]})
                            - $signed({1'b0, bus.b_pix[k*PIX_W +: PIX_W]});
                end
                if (r_s1_v) begin
                    r_sq[k] <= {{PIX_W{1'b0}}, w_abs[k]} * {{PIX_W{1'b0}}, w_abs[k]};
                end
                if (w_start) begin
                    r_acc[k] <= '0;
                end else if (r_s2_v) begin
                    r_acc[k] <= r_acc[k] + ACC_W'(r_sq[k]);
                end
`ifdef PIX_CMP_MAX_EN
                if (w_start) begin
                    r_max[k] <= '0;
                end else if (r_s1_v && (w_abs[k] > r_max[k])) begin
                    r_max[k] <= w_abs[k];
                end
`endif
            end
        end
    end

    generate
        for (genvar k = 0; k < CH_NUM; k++) begin : g_out
            assign bus.ch_loss[k*ACC_W +: ACC_W] = r_acc[k];
`ifdef PIX_CMP_MAX_EN
            assign bus.max_diff[k*PIX_W +: PIX_W] = r_max[k];
`endif
        end
    endgenerate

    assign bus.pix_ready  = w_ready;
    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.total_loss = r_total;
    assign bus.match      = r_match;

endmodule

`default_nettype wire

// File: tb/tb_pix_cmp_acc.sv
// +--------------------------------------------------------------------------+
// | tb_pix_cmp_acc : scoreboard bench for pix_cmp_acc on a 4x2, 3-channel    |
// | frame.  Rev 1.0                                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pix_cmp_acc;
    localparam int CH    = 3;
    localparam int PW    = 8;
    localparam int W     = 4;
    localparam int H     = 2;
    localparam int NPIX  = W * H;
    localparam int ACC_W = 2*PW + $clog2(NPIX) + 1;
    localparam int TOT_W = ACC_W + $clog2(CH) + 1;

    typedef struct packed {
        logic [CH*ACC_W-1:0] ch;
        logic [TOT_W-1:0]    tot;
        logic                m;
        logic [CH*PW-1:0]    mx;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_xfer = 0;
    int   xfers   = 0;
    exp_t sb[$];
    logic [CH*PW-1:0] a_arr [NPIX];
    logic [CH*PW-1:0] b_arr [NPIX];

    always #5 clk = ~clk;

    pix_cmp_acc_if #(.CH_NUM(CH), .PIX_W(PW), .WIDTH(W), .HEIGHT(H)) bus ();

    pix_cmp_acc #(.CH_NUM(CH), .PIX_W(PW), .WIDTH(W), .HEIGHT(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t model(input logic [TOT_W-1:0] thr);
        exp_t   e;
        longint acc [CH];
        longint mx  [CH];
        longint tot;
        int     d;
        e = '0;
        tot = 0;
        for (int k = 0; k < CH; k++) begin
            acc[k] = 0;
            mx[k]  = 0;
        end
        for (int p = 0; p < NPIX; p++) begin
            for (int k = 0; k < CH; k++) begin
                d = int'(a_arr[p][k*PW +: PW]) - int'(b_arr[p][k*PW +: PW]);
                acc[k] += longint'(d * d);
                if (d < 0) d = -d;
                if (longint'(d) > mx[k]) mx[k] = longint'(d);
            end
        end
        for (int k = 0; k < CH; k++) begin
            e.ch[k*ACC_W +: ACC_W] = acc[k][ACC_W-1:0];
            e.mx[k*PW +: PW]       = mx[k][PW-1:0];
            tot += acc[k];
        end
        e.tot = tot[TOT_W-1:0];
        e.m   = (tot <= longint'(thr));
        return e;
    endfunction

    // Transfer tracking and scoreboard checking at each done pulse.
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        if (!rst && bus.start && !bus.busy && !bus.done) xfers = 0;
        if (!rst && bus.pix_valid && bus.pix_ready) begin
            xfers++;
            last_xfer = cyc;
        end
        #1;
        if (bus.done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                for (int k = 0; k < CH; k++)
                    check($sformatf("ch_loss%0d", k), 64'(bus.ch_loss[k*ACC_W +: ACC_W]),
                          64'(e.ch[k*ACC_W +: ACC_W]));
                check("total_loss", 64'(bus.total_loss), 64'(e.tot));
                check("match", 64'(bus.match), 64'(e.m));
                check("latency", 64'(cyc - last_xfer), 64'd4);
                check("xfers", 64'(xfers), 64'(NPIX));
`ifdef PIX_CMP_MAX_EN
                for (int k = 0; k < CH; k++)
                    check($sformatf("max_diff%0d", k), 64'(bus.max_diff[k*PW +: PW]),
                          64'(e.mx[k*PW +: PW]));
`endif
            end
        end
    end

    task automatic check_cleared(input string tag);
        check({tag, "_ch_loss"}, 64'(bus.ch_loss), 64'd0);
        check({tag, "_total"}, 64'(bus.total_loss), 64'd0);
        check({tag, "_match"}, 64'(bus.match), 64'd0);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_done"}, 64'(bus.done), 64'd0);
        check({tag, "_ready"}, 64'(bus.pix_ready), 64'd0);
    endtask

    task automatic wait_done();
        int i;
        i = 0;
        while (sb.size() != 0 && i < 50) begin
            @(posedge clk);
            #2;
            i++;
        end
        if (sb.size() != 0) begin
            check("done_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    // abort_after >= 0 resets the block after that many transfers;
    // start_at >= 0 pulses start alongside that pixel while running.
    task automatic drive_frame(input logic [TOT_W-1:0] thr, input bit gaps,
                               input int abort_after, input int start_at);
        int p, guard;
        bit acc;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.threshold = thr;
        if (abort_after < 0) sb.push_back(model(thr));
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.threshold = TOT_W'($urandom);
        p = 0;
        guard = 0;
        while (p < NPIX && guard < 1000) begin
            guard++;
            if (abort_after >= 0 && p == abort_after) break;
            if (gaps && $urandom_range(0, 1) == 0) begin
                bus.pix_valid = 1'b0;
            end else begin
                bus.pix_valid = 1'b1;
                bus.a_pix = a_arr[p];
                bus.b_pix = b_arr[p];
            end
            bus.start = (p == start_at) && bus.pix_valid;
            acc = bus.pix_valid && bus.pix_ready;
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (acc) p++;
        end
        if (guard >= 1000) check("accept_timeout", 64'(p), 64'(NPIX));
        if (abort_after >= 0) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            bus.pix_valid = 1'b0;
            check_cleared("abort");
            repeat (10) @(posedge clk);
            #1;
        end else begin
            bus.pix_valid = 1'b1;
            check("drain_busy", 64'(bus.busy), 64'd1);
            check("drain_ready", 64'(bus.pix_ready), 64'd0);
            wait_done();
            bus.pix_valid = 1'b0;
        end
    endtask

    task automatic fill_const(input logic [CH*PW-1:0] a, input logic [CH*PW-1:0] b);
        for (int p = 0; p < NPIX; p++) begin
            a_arr[p] = a;
            b_arr[p] = b;
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.threshold = '0;
        bus.pix_valid = 1'b0;
        bus.a_pix = '0;
        bus.b_pix = '0;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        rst = 1'b0;

        // start coinciding with reset is dropped
        rst = 1'b1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.start = 1'b0;
        check("rst_start_busy", 64'(bus.busy), 64'd0);

        for (int p = 0; p < NPIX; p++) begin
            a_arr[p] = (CH*PW)'($urandom);
            b_arr[p] = a_arr[p];
        end
        drive_frame('0, 1'b0, -1, -1);

        fill_const({8'd30, 8'd20, 8'd10}, {8'd30, 8'd16, 8'd13});
        drive_frame(TOT_W'(199), 1'b0, -1, -1);
        drive_frame(TOT_W'(200), 1'b0, -1, -1);

        fill_const({CH*PW{1'b1}}, '0);
        drive_frame(TOT_W'(1560600), 1'b0, -1, -1);

        fill_const({8'd30, 8'd20, 8'd10}, {8'd30, 8'd16, 8'd13});
        drive_frame(TOT_W'(200), 1'b1, -1, -1);

        drive_frame(TOT_W'(200), 1'b0, 5, -1);
        drive_frame(TOT_W'(199), 1'b0, -1, 3);

`ifdef PIX_CMP_MAX_EN
        for (int p = 0; p < NPIX; p++) begin
            a_arr[p] = {8'd7, 8'd50, 8'd9};
            b_arr[p] = a_arr[p];
        end
        a_arr[2] = {8'd7, 8'd100, 8'd9};
        b_arr[2] = {8'd7, 8'd40, 8'd9};
        drive_frame(TOT_W'(3600), 1'b1, -1, -1);
`endif

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
